// File: rtl/preact_accumulator.sv
// Multiply-accumulate stage feeding the PLA tanh unit. Sums N_TERMS signed
// operand products plus a bias at full precision, then rounds half-up and
// saturates to the signed fixed-point pre-activation word. The result is held
// until the downstream stage accepts it.
module preact_accumulator #(
  parameter int unsigned W_DATA  = 10,
  parameter int unsigned DATA_I  = 4,
  parameter int unsigned W_OUT   = 10,
  parameter int unsigned OUT_I   = 4,
  parameter int unsigned N_TERMS = 8,
  parameter int unsigned W_ACC   = 24
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [W_DATA-1:0] in_a,
  input  logic signed [W_DATA-1:0] in_b,
  input  logic signed [W_DATA-1:0] in_bias,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [W_OUT-1:0]  out,
  output logic                     out_sat
);

  localparam int unsigned FD = W_DATA - DATA_I;
  localparam int unsigned FO = W_OUT - OUT_I;
  localparam int unsigned S  = 2 * FD - FO;
  localparam int unsigned CW = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
  localparam logic [CW-1:0] LAST = CW'(N_TERMS - 1);

  localparam longint OMAX = (longint'(1) << (W_OUT - 1)) - 1;
  localparam logic signed [W_ACC-1:0] OUT_MAX = W_ACC'(OMAX);
  localparam logic signed [W_ACC-1:0] OUT_MIN = ~OUT_MAX;

  // Reject configurations where the accumulator could wrap or rounding is ill-defined.
  if (W_ACC < 2 * W_DATA + $clog2(N_TERMS) + 1) begin : g_bad_acc
    $error("preact_accumulator: W_ACC too narrow");
  end
  if (FO > 2 * FD) begin : g_bad_fo
    $error("preact_accumulator: FO must not exceed 2*FD");
  end
  if (N_TERMS < 1) begin : g_bad_terms
    $error("preact_accumulator: N_TERMS must be at least 1");
  end

  typedef enum logic [1:0] {StAcc, StRound, StHold} state_e;

  state_e                   r_state, w_state_nxt;
  logic signed [W_ACC-1:0]  r_acc, w_acc_nxt;
  logic [CW-1:0]            r_count, w_count_nxt;
  logic signed [W_OUT-1:0]  r_out, w_out_nxt;
  logic                     r_sat, w_sat_nxt;

  logic signed [2*W_DATA-1:0] w_prod;
  logic signed [W_ACC-1:0]    w_prod_ext;
  logic signed [W_ACC-1:0]    w_bias_ext;
  logic signed [W_ACC-1:0]    w_rnd;

  assign w_prod     = in_a * in_b;
  assign w_prod_ext = W_ACC'(w_prod);
  // Bias is in operand format; align it to the product's 2*FD fraction bits.
  assign w_bias_ext = W_ACC'(in_bias) <<< FD;

  // Round half up to FO fraction bits (arithmetic shift keeps the sign).
  if (S == 0) begin : g_no_round
    assign w_rnd = r_acc;
  end else begin : g_round
    assign w_rnd = (r_acc + (W_ACC'(1) <<< (S - 1))) >>> S;
  end

  // Next-state, datapath and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_count_nxt = r_count;
    w_out_nxt   = r_out;
    w_sat_nxt   = r_sat;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      StAcc: begin
        in_ready = 1'b1;
        if (in_valid) begin
          // First term of a frame restarts from the bias, so no residue carries over.
          w_acc_nxt   = (r_count == '0) ? (w_bias_ext + w_prod_ext) : (r_acc + w_prod_ext);
          w_count_nxt = r_count + 1'b1;
          if (r_count == LAST) begin
            w_state_nxt = StRound;
          end
        end
      end
      StRound: begin
        if (w_rnd > OUT_MAX) begin
          w_out_nxt = OUT_MAX[W_OUT-1:0];
          w_sat_nxt = 1'b1;
        end else if (w_rnd < OUT_MIN) begin
          w_out_nxt = OUT_MIN[W_OUT-1:0];
          w_sat_nxt = 1'b1;
        end else begin
          w_out_nxt = w_rnd[W_OUT-1:0];
          w_sat_nxt = 1'b0;
        end
        w_state_nxt = StHold;
      end
      StHold: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_acc_nxt   = '0;
          w_count_nxt = '0;
          w_state_nxt = StAcc;
        end
      end
      default: begin
        w_state_nxt = StAcc;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= StAcc;
      r_acc   <= '0;
      r_count <= '0;
      r_out   <= '0;
      r_sat   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_count <= w_count_nxt;
      r_out   <= w_out_nxt;
      r_sat   <= w_sat_nxt;
    end
  end

  assign out     = r_out;
  assign out_sat = r_sat;

endmodule

// File: tb/tb_preact_accumulator.sv
// Directed bench for preact_accumulator: reset, nominal frame with input gaps,
// saturation both ways, rounding, output backpressure and mid-frame reset.
module tb_preact_accumulator;

  localparam logic [9:0] ZERO  = 10'b0000_000000;
  localparam logic [9:0] ONE   = 10'b0001_000000;
  localparam logic [9:0] HALF  = 10'b0000_100000;
  localparam logic [9:0] THREE = 10'b0011_000000;
  localparam logic [9:0] M3    = 10'b1101_000000;
  localparam logic [9:0] M8    = 10'b1000_000000;
  localparam logic [9:0] LSB   = 10'b0000_000001;
  localparam logic [9:0] MLSB  = 10'b1111_111111;
  localparam logic [9:0] PMAX  = 10'b0111_111111;

  logic       clock = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [9:0] in_a;
  logic [9:0] in_b;
  logic [9:0] in_bias;
  logic       out_valid;
  logic       out_ready;
  logic [9:0] out_w;
  logic       out_sat;

  int n_vec = 0;
  int n_err = 0;

  preact_accumulator #(
    .W_DATA (10),
    .DATA_I (4),
    .W_OUT  (10),
    .OUT_I  (4),
    .N_TERMS(8),
    .W_ACC  (24)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_bias  (in_bias),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (out_w),
    .out_sat  (out_sat)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Term 0 uses a0/b0, later terms use a/b; gap_after inserts 2 idle cycles after that term.
  task automatic feed_frame(input logic [9:0] bias, input logic [9:0] a0, input logic [9:0] b0,
                            input logic [9:0] a, input logic [9:0] b, input int gap_after,
                            input int n_terms);
    for (int i = 0; i < n_terms; i++) begin
      check("in_ready_term", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1;
      in_bias  = bias;
      in_a     = (i == 0) ? a0 : a;
      in_b     = (i == 0) ? b0 : b;
      tick();
      in_valid = 1'b0;
      if (i + 1 == gap_after) begin
        tick();
        tick();
      end
    end
  endtask

  task automatic collect(input string tag, input logic [9:0] exp_out, input logic exp_sat);
    int k = 0;
    while (out_valid !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_out"}, {22'd0, out_w}, {22'd0, exp_out});
    check({tag, "_sat"}, {31'd0, out_sat}, {31'd0, exp_sat});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_ack_ready"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_ack_valid"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_a      = ZERO;
    in_b      = ZERO;
    in_bias   = ZERO;
    out_ready = 1'b0;

    // 1: reset then idle
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_out", {22'd0, out_w}, 32'd0);
      check("idle_valid", {31'd0, out_valid}, 32'd0);
      check("idle_sat", {31'd0, out_sat}, 32'd0);
      check("idle_ready", {31'd0, in_ready}, 32'd1);
    end

    // 2: -3.0 + 8 * 0.5 = 1.0, gap after term 3, latency check
    feed_frame(M3, ONE, HALF, ONE, HALF, 3, 8);
    check("lat_round_valid", {31'd0, out_valid}, 32'd0);
    check("lat_round_ready", {31'd0, in_ready}, 32'd0);
    tick();
    check("lat_hold_valid", {31'd0, out_valid}, 32'd1);
    collect("nominal", ONE, 1'b0);

    // 3: positive and negative saturation
    feed_frame(ZERO, THREE, THREE, THREE, THREE, 0, 8);
    collect("sat_pos", PMAX, 1'b1);
    feed_frame(ZERO, M8, THREE, M8, THREE, 0, 8);
    collect("sat_neg", M8, 1'b1);

    // 4: rounding of half-LSB values
    feed_frame(ZERO, LSB, HALF, ZERO, ZERO, 0, 8);
    collect("round_up", LSB, 1'b0);
    feed_frame(ZERO, MLSB, HALF, ZERO, ZERO, 0, 8);
    collect("round_neg", ZERO, 1'b0);

    // 5: backpressure with input pressure, then a clean frame
    feed_frame(ZERO, THREE, THREE, THREE, THREE, 0, 8);
    tick();
    check("bp_valid", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b1;
    in_a     = THREE;
    in_b     = THREE;
    in_bias  = THREE;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_out", {22'd0, out_w}, {22'd0, PMAX});
      check("bp_hold_sat", {31'd0, out_sat}, 32'd1);
      check("bp_hold_ready", {31'd0, in_ready}, 32'd0);
      check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_release_ready", {31'd0, in_ready}, 32'd1);
    feed_frame(M3, ONE, HALF, ONE, HALF, 0, 8);
    collect("bp_next", ONE, 1'b0);

    // 6: reset mid-frame (with in_valid high) discards partial frame
    feed_frame(ONE, THREE, THREE, THREE, THREE, 0, 3);
    in_valid = 1'b1;
    reset    = 1'b1;
    tick();
    reset    = 1'b0;
    in_valid = 1'b0;
    check("rst_out", {22'd0, out_w}, 32'd0);
    check("rst_sat", {31'd0, out_sat}, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    feed_frame(M3, ONE, HALF, ONE, HALF, 0, 8);
    collect("post_rst", ONE, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
